// File: rtl/uart_rx_deframer_pkg.sv
// rtl/uart_rx_deframer_pkg.sv - shared UART receive definitions
// Purpose: FSM state encoding, oversampling default and baud divider helper,
//          shared by the RX deframer and the planned TX serialiser.
// Ports:   none (package)
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_t;

  localparam int OVS_DEFAULT = 16;

  // Clocks per oversampling tick, rounded down.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_baud_tick.sv
// rtl/uart_rx_deframer_baud_tick.sv - oversampling tick generator
// Purpose: counts 0..DIV-1 and emits a one-cycle tick on DIV-1; clr restarts
//          the count so ticks are phase-aligned to a detected start edge.
// Ports:   clk  in  system clock
//          rst  in  asynchronous active-low reset
//          clr  in  synchronous counter clear
//          tick out one-cycle pulse every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receiver with one-byte holding register
// Purpose: synchronises the RX pin, samples each bit at its centre using an
//          oversampling tick, deframes 8N1 characters (LSB first) and holds
//          one byte for the consumer; flags framing errors and overruns.
// Ports:   clk      in   system clock
//          rst      in   asynchronous active-low reset
//          uart_rxd in   serial line, idle high
//          rd       in   one-cycle read strobe
//          drec     out  last accepted byte
//          avail    out  byte waiting in drec
//          ferr     out  framing error pulse
//          ovf      out  sticky overrun, cleared by rd
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200,
  parameter int OVS      = OVS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       rd,
  output logic [7:0] drec,
  output logic       avail,
  output logic       ferr,
  output logic       ovf
);

  localparam int DIV = calc_div(clk_freq, baud, OVS);
  localparam int SW  = $clog2(OVS);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

  logic            r_sync1;
  logic            r_rxs;
  rx_state_t       r_state;
  logic [SW-1:0]   r_s;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_drec;
  logic            r_avail;
  logic            r_ferr;
  logic            r_ovf;
  logic            w_tick;
  logic            w_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxs   <= r_sync1;
    end
  end

  // Restart tick phase on the start edge so samples land at bit centres.
  assign w_clr = (r_state == ST_IDLE) && !r_rxs;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_drec  <= '0;
      r_avail <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;

      if (w_clr) begin
        r_s <= '0;
      end else if (w_tick) begin
        r_s <= r_s + SW'(1);
      end

      if (rd && r_avail) begin
        r_avail <= 1'b0;
        r_ovf   <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (!r_rxs) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick && (r_s == S_MID)) begin
            if (r_rxs) begin
              r_state <= ST_IDLE;       // too short to be a start bit
            end else begin
              r_state <= ST_DATA;
              r_s     <= '0;
              r_idx   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (w_tick && (r_s == S_LAST)) begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick && (r_s == S_LAST)) begin
            if (r_rxs) begin
              r_state <= ST_IDLE;
              // A read in this cycle frees the holding register for the new byte.
              if (!r_avail || rd) begin
                r_drec  <= r_shift;
                r_avail <= 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_HI;
            end
          end
        end
        ST_WAIT_HI: begin
          if (r_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign drec  = r_drec;
  assign avail = r_avail;
  assign ferr  = r_ferr;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

  localparam int DIV = 27;
  localparam int OVS = 16;
  localparam int BIT = DIV * OVS;
  // Pin change to stop-bit mid-sample: two sync flops plus the IDLE decision,
  // then half a start bit, eight data bits and one stop bit of ticks.
  localparam int ACCEPT_LAT = 3 + (OVS / 2 + 9 * OVS) * DIV;

  typedef enum int {OP_SEND, OP_BAD, OP_RD, OP_GLITCH} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       exp_avail;
    logic [7:0] exp_drec;
    logic       exp_ovf;
    int         exp_ferr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       uart_rxd;
  logic       rd;
  logic [7:0] drec;
  logic       avail;
  logic       ferr;
  logic       ovf;

  int n_pass;
  int n_total;
  int ferr_cnt;
  int ferr_base;

  logic       m_avail;
  logic [7:0] m_drec;
  logic       m_ovf;

  vec_t vecs[13];

  uart_rx_deframer #(
    .clk_freq (50000000),
    .baud     (115200),
    .OVS      (OVS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rd       (rd),
    .drec     (drec),
    .avail    (avail),
    .ferr     (ferr),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cnt = ferr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  task automatic check_state(input string tag, input logic ea, input logic [7:0] ed,
                             input logic eo, input int ef);
    @(negedge clk);
    chk({tag, "_avail"}, {31'd0, avail}, {31'd0, ea});
    chk({tag, "_drec"},  {24'd0, drec},  {24'd0, ed});
    chk({tag, "_ovf"},   {31'd0, ovf},   {31'd0, eo});
    chk({tag, "_ferr"},  ferr_cnt - ferr_base, ef);
  endtask

  task automatic drive_bits(input logic v, input int nbits);
    uart_rxd = v;
    repeat (nbits * BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop);
    @(posedge clk);
    #1;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
    if (bad_stop) drive_bits(1'b0, 2);
    drive_bits(1'b1, 1);
  endtask

  task automatic send_glitch();
    @(posedge clk);
    #1 uart_rxd = 1'b0;
    repeat (100) @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic do_rd();
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b);
    if (!m_avail) begin
      m_drec  = b;
      m_avail = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_rd();
    if (m_avail) begin
      m_avail = 1'b0;
      m_ovf   = 1'b0;
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    ferr_cnt  = 0;
    ferr_base = 0;
    rst       = 1'b0;
    uart_rxd  = 1'b1;
    rd        = 1'b0;

    vecs[0]  = '{OP_SEND,   8'h55, 1'b1, 8'h55, 1'b0, 0};
    vecs[1]  = '{OP_RD,     8'h00, 1'b0, 8'h55, 1'b0, 0};
    vecs[2]  = '{OP_SEND,   8'hA3, 1'b1, 8'hA3, 1'b0, 0};
    vecs[3]  = '{OP_RD,     8'h00, 1'b0, 8'hA3, 1'b0, 0};
    vecs[4]  = '{OP_GLITCH, 8'h00, 1'b0, 8'hA3, 1'b0, 0};
    vecs[5]  = '{OP_BAD,    8'h3C, 1'b0, 8'hA3, 1'b0, 1};
    vecs[6]  = '{OP_SEND,   8'h81, 1'b1, 8'h81, 1'b0, 0};
    vecs[7]  = '{OP_RD,     8'h00, 1'b0, 8'h81, 1'b0, 0};
    vecs[8]  = '{OP_SEND,   8'h11, 1'b1, 8'h11, 1'b0, 0};
    vecs[9]  = '{OP_SEND,   8'h22, 1'b1, 8'h11, 1'b1, 0};
    vecs[10] = '{OP_RD,     8'h00, 1'b0, 8'h11, 1'b0, 0};
    vecs[11] = '{OP_SEND,   8'h33, 1'b1, 8'h33, 1'b0, 0};
    vecs[12] = '{OP_RD,     8'h00, 1'b0, 8'h33, 1'b0, 0};

    // Reset values
    repeat (5) @(posedge clk);
    ferr_base = ferr_cnt;
    check_state("reset", 1'b0, 8'h00, 1'b0, 0);
    chk("reset_ferr_level", {31'd0, ferr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      ferr_base = ferr_cnt;
      case (vecs[i].op)
        OP_SEND:   send_frame(vecs[i].data, 1'b0);
        OP_BAD:    send_frame(vecs[i].data, 1'b1);
        OP_RD:     do_rd();
        OP_GLITCH: send_glitch();
        default:   do_rd();
      endcase
      check_state($sformatf("vec%0d", i), vecs[i].exp_avail, vecs[i].exp_drec,
                  vecs[i].exp_ovf, vecs[i].exp_ferr);
    end

    // Read on the exact cycle the second byte is accepted
    ferr_base = ferr_cnt;
    send_frame(8'h5A, 1'b0);
    check_state("coinc_first", 1'b1, 8'h5A, 1'b0, 0);
    ferr_base = ferr_cnt;
    fork
      send_frame(8'hC7, 1'b0);
      begin
        @(posedge clk);
        repeat (ACCEPT_LAT - 1) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    check_state("coinc_second", 1'b1, 8'hC7, 1'b0, 0);

    // Reset in the middle of data bit 4 of 0xF0
    ferr_base = ferr_cnt;
    fork
      send_frame(8'hF0, 1'b0);
      begin
        @(posedge clk);
        repeat (BIT * 5 + BIT / 2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_avail", {31'd0, avail}, 32'd0);
        chk("rstmid_drec",  {24'd0, drec},  32'd0);
        chk("rstmid_ovf",   {31'd0, ovf},   32'd0);
        chk("rstmid_ferr",  {31'd0, ferr},  32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    check_state("rstmid_after", 1'b0, 8'h00, 1'b0, 0);
    ferr_base = ferr_cnt;
    send_frame(8'h0F, 1'b0);
    check_state("rstmid_0F", 1'b1, 8'h0F, 1'b0, 0);

    // Randomised frames against the reference model
    m_avail = 1'b1;
    m_drec  = 8'h0F;
    m_ovf   = 1'b0;
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      bit         bad;
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      ferr_base = ferr_cnt;
      send_frame(b, bad);
      if (!bad) model_frame(b);
      check_state($sformatf("rnd%0d_frame", r), m_avail, m_drec, m_ovf, bad ? 1 : 0);
      if ($urandom_range(0, 1) == 1) begin
        ferr_base = ferr_cnt;
        do_rd();
        model_rd();
        check_state($sformatf("rnd%0d_rd", r), m_avail, m_drec, m_ovf, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
